seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 144 ++++++++++++++
 tb/tb_seq_divider.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, under a start/done handshake.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  logic [1:0]    state_q, state_d;
  logic [VW-1:0] r_q, r_d;
  logic [DW-1:0] qsr_q, qsr_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   t_s;
  logic [VW:0]   sub_s;
  logic          ge_s;
  logic [VW-1:0] r_step_s;
  logic [DW-1:0] qsr_step_s;

  // One restoring step. The partial remainder stays below the divisor, so
  // t < 2*divisor and the top bit of t - divisor is exactly the borrow.
  always_comb begin
    t_s        = {r_q, qsr_q[DW-1]};
    sub_s      = t_s - {1'b0, dvs_q};
    ge_s       = ~sub_s[VW];
    r_step_s   = ge_s ? sub_s[VW-1:0] : t_s[VW-1:0];
    qsr_step_s = {qsr_q[DW-2:0], ge_s};
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    qsr_d   = qsr_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor == {VW{1'b0}}) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            quo_d   = {DW{1'b1}};
            rem_d   = dividend[VW-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            r_d     = {VW{1'b0}};
            qsr_d   = dividend;
            dvs_d   = divisor;
            cnt_d   = {CW{1'b0}};
            busy_d  = 1'b1;
            quo_d   = {DW{1'b0}};
            rem_d   = {VW{1'b0}};
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        r_d   = r_step_s;
        qsr_d = qsr_step_s;
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = qsr_step_s;
          rem_d   = r_step_s;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= {VW{1'b0}};
      qsr_q   <= {DW{1'b0}};
      dvs_q   <= {VW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= {DW{1'b0}};
      rem_q   <= {VW{1'b0}};
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      qsr_q   <= qsr_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, hand-written
// multi-cycle sequences, and a random invariant sweep.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called on the negedge right after acceptance with cyc = cycles elapsed.
  task automatic wait_done(input int cyc0, output int cyc, output int busy_cnt);
    cyc = cyc0;
    busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_div(input string name, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez);
    int cyc, bc;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, cyc, bc);
    chk({name, ".latency"}, cyc, (b == 8'd0) ? 32'd1 : 32'd17);
    chk({name, ".busy_cycles"}, bc, (b == 8'd0) ? 32'd0 : 32'd16);
    chk({name, ".busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({name, ".quotient"}, {16'd0, quotient}, {16'd0, eq});
    chk({name, ".remainder"}, {24'd0, remainder}, {24'd0, er});
    chk({name, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    chk({name, ".done_drop"}, {31'd0, done}, 32'd0);
    chk({name, ".q_hold"}, {16'd0, quotient}, {16'd0, eq});
  endtask

  initial begin
    int cyc, bc, pulses;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic [31:0] lhs;

    vecs[0] = '{16'd50000, 8'd7,   16'd7142,  8'd6,   1'b0};
    vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5,   1'b0};
    vecs[4] = '{16'd0,     8'd9,   16'd0,     8'd0,   1'b0};
    vecs[5] = '{16'd100,   8'd0,   16'hFFFF,  8'd100, 1'b1};
    vecs[6] = '{16'd65025, 8'd255, 16'd255,   8'd0,   1'b0};
    vecs[7] = '{16'd12345, 8'd123, 16'd100,   8'd45,  1'b0};
    vecs[8] = '{16'd40000, 8'd13,  16'd3076,  8'd12,  1'b0};
    vecs[9] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,  1'b1};

    rst_n = 1'b0; start = 1'b0; dividend = 16'd0; divisor = 8'd0;
    #12;
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.quotient", {16'd0, quotient}, 32'd0);
    chk("reset.remainder", {24'd0, remainder}, 32'd0);
    chk("reset.dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

    // start during RUN is ignored; start in DONE is taken back-to-back
    @(negedge clk);
    start = 1'b1; dividend = 16'd1000; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd9; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, cyc, bc);
    chk("ign.latency", cyc, 32'd17);
    chk("ign.quotient", {16'd0, quotient}, 32'd333);
    chk("ign.remainder", {24'd0, remainder}, 32'd1);
    start = 1'b1; dividend = 16'd9; divisor = 8'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b.done_drop", {31'd0, done}, 32'd0);
    chk("b2b.busy_rise", {31'd0, busy}, 32'd1);
    wait_done(1, cyc, bc);
    chk("b2b.latency", cyc, 32'd17);
    chk("b2b.quotient", {16'd0, quotient}, 32'd1);
    chk("b2b.remainder", {24'd0, remainder}, 32'd0);

    // Held-high start with zero divisor pulses done every cycle
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold0.done%0d", k), {31'd0, done}, 32'd1);
      chk($sformatf("hold0.busy%0d", k), {31'd0, busy}, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("hold0.done_end", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-run aborts without a done
    @(negedge clk);
    start = 1'b1; dividend = 16'd40000; divisor = 8'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort.busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.quotient", {16'd0, quotient}, 32'd0);
    chk("abort.remainder", {24'd0, remainder}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort.no_activity", pulses, 32'd0);
    do_div("after_abort", 16'd40000, 8'd13, 16'd3076, 8'd12, 1'b0);

    // Random sweep checked against the division invariant
    for (int n = 0; n < 400; n++) begin
      ra = 16'($urandom);
      rb = (n % 8 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b1; dividend = ra; divisor = rb;
      @(negedge clk);
      start = 1'b0;
      wait_done(1, cyc, bc);
      if (rb == 8'd0) begin
        chk($sformatf("rand%0d.zero", n),
            {7'd0, done, div_by_zero, quotient, remainder},
            {7'd0, 1'b1, 1'b1, 16'hFFFF, ra[7:0]});
      end else begin
        lhs = 32'(quotient) * 32'(rb) + 32'(remainder);
        chk($sformatf("rand%0d.inv", n),
            {29'd0, done, (remainder < rb), div_by_zero, 1'b0} | ((lhs == 32'(ra)) ? 32'd1 : 32'd0),
            {29'd0, 1'b1, 1'b1, 1'b0, 1'b1});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
